// File: rtl/inst_mem_pkg.sv
// Shared types and helpers for the banked instruction memory.
package inst_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] FILL_DEFAULT = 8'hFF;

  // Flat word address of (bank, addr) for banks of the given depth.
  function automatic int unsigned bank_index(input int unsigned bank,
                                             input int unsigned addr,
                                             input int unsigned depth);
    return bank * depth + addr;
  endfunction

endpackage

// File: rtl/inst_mem_array.sv
// Single-port synchronous RAM with registered read and FILL power-up contents.
// Optional even-parity column when INST_MEM_PARITY_EN is defined.
module inst_mem_array
  import inst_mem_pkg::*;
#(
  parameter int unsigned       DATA_W = 8,
  parameter int unsigned       DEPTH  = 1024,
  parameter int unsigned       AW     = 10,
  parameter logic [DATA_W-1:0] FILL   = DATA_W'(FILL_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd_fill,
  output logic [DATA_W-1:0] rdata
`ifdef INST_MEM_PARITY_EN
  ,
  output logic              parity_err
`endif
);

`ifdef INST_MEM_PARITY_EN
  localparam int unsigned          WORD_W    = DATA_W + 1;
  localparam logic [WORD_W-1:0]    INIT_WORD = {^FILL, FILL};
`else
  localparam int unsigned          WORD_W    = DATA_W;
  localparam logic [WORD_W-1:0]    INIT_WORD = FILL;
`endif

  // Contents survive rst_n; only power-up sets them to FILL.
  logic [WORD_W-1:0] mem [DEPTH] = '{default: INIT_WORD};
  logic [WORD_W-1:0] wword;
  logic [WORD_W-1:0] rd_word;
  logic [DATA_W-1:0] rdata_q, rdata_d;
`ifdef INST_MEM_PARITY_EN
  logic              perr_q, perr_d;
`endif

  always_comb begin
`ifdef INST_MEM_PARITY_EN
    wword = {^wdata, wdata};
`else
    wword = wdata;
`endif
  end

  always @(posedge clk) begin
    if (en && we) mem[addr] <= wword;
  end

  assign rd_word = mem[addr];

  // Read register holds its value between accepted reads.
  always_comb begin
    rdata_d = rdata_q;
`ifdef INST_MEM_PARITY_EN
    perr_d  = 1'b0;
`endif
    if (en && !we) begin
      if (rd_fill) begin
        rdata_d = FILL;
      end else begin
        rdata_d = rd_word[DATA_W-1:0];
`ifdef INST_MEM_PARITY_EN
        perr_d  = ^rd_word;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= FILL;
`ifdef INST_MEM_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      rdata_q <= rdata_d;
`ifdef INST_MEM_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign rdata = rdata_q;
`ifdef INST_MEM_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule

// File: rtl/inst_mem_banked.sv
// Banked instruction memory with 1-cycle fetch and a streaming bank loader.
// Define INST_MEM_PARITY_EN to add per-word parity and the parity_err output.
module inst_mem_banked
  import inst_mem_pkg::*;
#(
  parameter int unsigned       DATA_W     = 8,
  parameter int unsigned       ADDR_W     = 8,
  parameter int unsigned       BANK_DEPTH = 256,
  parameter int unsigned       NUM_PROG   = 4,
  parameter logic [DATA_W-1:0] FILL       = DATA_W'(FILL_DEFAULT),
  localparam int unsigned      PSEL_W     = (NUM_PROG > 1) ? $clog2(NUM_PROG) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PSEL_W-1:0] prog_sel,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_o,
  input  logic              load_start,
  input  logic [PSEL_W-1:0] load_bank,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic              load_ovf
`ifdef INST_MEM_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int unsigned IDX_W     = PSEL_W + ADDR_W;
  localparam int unsigned MEM_DEPTH = NUM_PROG * BANK_DEPTH;
  localparam int unsigned MEM_AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned WPTR_W    = $clog2(BANK_DEPTH + 1);

  state_e              state_q, state_d;
  logic [PSEL_W-1:0]   bank_q, bank_d;
  logic [WPTR_W-1:0]   wptr_q, wptr_d;
  logic                load_ovf_q, load_ovf_d;
  logic                load_done_q, load_done_d;
  logic                inst_valid_q, inst_valid_d;
  logic                fetch_acc, fetch_oor, wr_en;
  logic [IDX_W-1:0]    fetch_idx, wr_idx;
  logic [MEM_AW-1:0]   ram_addr;

  assign fetch_ready = (state_q == IDLE);
  assign load_ready  = (state_q == LOAD);
  assign fetch_acc   = fetch_req && fetch_ready;
  assign fetch_oor   = (32'(fetch_addr) >= BANK_DEPTH) || (32'(prog_sel) >= NUM_PROG);

  assign fetch_idx = IDX_W'(bank_index(32'(prog_sel), 32'(fetch_addr), BANK_DEPTH));
  assign wr_idx    = IDX_W'(bank_index(32'(bank_q), 32'(wptr_q), BANK_DEPTH));
  assign ram_addr  = wr_en ? MEM_AW'(wr_idx) : MEM_AW'(fetch_idx);

  // Loader FSM: beats past the end of the bank are dropped and flagged.
  always_comb begin
    state_d      = state_q;
    bank_d       = bank_q;
    wptr_d       = wptr_q;
    load_ovf_d   = load_ovf_q;
    load_done_d  = 1'b0;
    inst_valid_d = fetch_acc;
    wr_en        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d    = LOAD;
          bank_d     = load_bank;
          wptr_d     = '0;
          load_ovf_d = 1'b0;
        end
      end
      LOAD: begin
        if (load_valid) begin
          if (wptr_q == WPTR_W'(BANK_DEPTH)) begin
            load_ovf_d = 1'b1;
          end else begin
            wr_en  = (32'(bank_q) < NUM_PROG);
            wptr_d = wptr_q + WPTR_W'(1);
          end
          if (load_last) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    load_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bank_q       <= '0;
      wptr_q       <= '0;
      load_ovf_q   <= 1'b0;
      load_done_q  <= 1'b0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bank_q       <= bank_d;
      wptr_q       <= wptr_d;
      load_ovf_q   <= load_ovf_d;
      load_done_q  <= load_done_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign load_ovf   = load_ovf_q;
  assign load_done  = load_done_q;
  assign inst_valid = inst_valid_q;

  inst_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (MEM_DEPTH),
    .AW     (MEM_AW),
    .FILL   (FILL)
  ) u_array (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (fetch_acc || wr_en),
    .we         (wr_en),
    .addr       (ram_addr),
    .wdata      (load_data),
    .rd_fill    (fetch_oor),
    .rdata      (inst_o)
`ifdef INST_MEM_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

endmodule

// File: tb/tb_inst_mem_banked.sv
// Self-checking bench for inst_mem_banked against an array-based reference model.
module tb_inst_mem_banked;

  localparam int unsigned DW = 8, AW = 8, DEPTH = 4, NP = 5, PW = 3;
  localparam logic [7:0]  FILLV = 8'hFF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [PW-1:0] prog_sel = '0;
  logic          fetch_req = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic          fetch_ready, inst_valid, load_ready, load_done, load_ovf;
  logic [DW-1:0] inst_o;
  logic          load_start = 1'b0;
  logic [PW-1:0] load_bank = '0;
  logic          load_valid = 1'b0;
  logic [DW-1:0] load_data = '0;
  logic          load_last = 1'b0;
`ifdef INST_MEM_PARITY_EN
  logic          parity_err;
`endif

  int total = 0;
  int bad = 0;
  logic [7:0] model [NP][DEPTH];
  logic [7:0] beats [$];

  inst_mem_banked #(
    .DATA_W(DW), .ADDR_W(AW), .BANK_DEPTH(DEPTH), .NUM_PROG(NP), .FILL(FILLV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .prog_sel(prog_sel), .fetch_req(fetch_req),
    .fetch_addr(fetch_addr), .fetch_ready(fetch_ready), .inst_valid(inst_valid),
    .inst_o(inst_o), .load_start(load_start), .load_bank(load_bank),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .load_done(load_done), .load_ovf(load_ovf)
`ifdef INST_MEM_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_read(input int sel, input int addr);
    if (sel >= int'(NP) || addr >= int'(DEPTH)) return FILLV;
    return model[sel][addr];
  endfunction

  task automatic model_load(input int bank, input int n);
    for (int i = 0; i < n && i < int'(DEPTH); i++) model[bank][i] = beats[i];
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_one(input int sel, input int addr, output logic v,
                           output logic [7:0] d, output logic pe);
    prog_sel = PW'(sel); fetch_addr = AW'(addr); fetch_req = 1'b1;
    tick;
    fetch_req = 1'b0;
    v = inst_valid; d = inst_o;
`ifdef INST_MEM_PARITY_EN
    pe = parity_err;
`else
    pe = 1'b0;
`endif
  endtask

  task automatic run_load(input int bank, input bit with_last, output int dones);
    dones = 0;
    load_bank = PW'(bank); load_start = 1'b1;
    tick;
    load_start = 1'b0;
    foreach (beats[i]) begin
      load_valid = 1'b1; load_data = beats[i];
      load_last = with_last && (i == beats.size() - 1);
      tick;
      if (load_done) dones++;
    end
    load_valid = 1'b0; load_last = 1'b0;
    if (with_last) for (int k = 0; k < 3; k++) begin tick; if (load_done) dones++; end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; tick; tick;
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", inst_valid); end
    total++; if (inst_o !== FILLV) begin bad++; $display("FAIL reset_inst got=%h exp=%h", inst_o, FILLV); end
    total++; if (load_done !== 1'b0 || load_ovf !== 1'b0) begin bad++; $display("FAIL reset_load got=%b%b exp=00", load_done, load_ovf); end
    total++; if (fetch_ready !== 1'b1 || load_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b%b exp=10", fetch_ready, load_ready); end
`ifdef INST_MEM_PARITY_EN
    total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b exp=0", parity_err); end
`endif
    rst_n = 1'b1; tick;
  endtask

  task automatic test_unloaded_fetch;
    logic v, pe; logic [7:0] d;
    fetch_one(0, 2, v, d, pe);
    total++; if (v !== 1'b1 || d !== FILLV) begin bad++; $display("FAIL unloaded got=%b/%h exp=1/%h", v, d, FILLV); end
    tick;
    total++; if (inst_valid !== 1'b0 || inst_o !== FILLV) begin bad++; $display("FAIL valid_fall got=%b/%h exp=0/%h", inst_valid, inst_o, FILLV); end
  endtask

  task automatic test_load_back_to_back;
    int dn; logic v, pe; logic [7:0] d;
    beats = '{8'hC1, 8'h90, 8'h88};
    run_load(1, 1'b1, dn);
    model_load(1, 3);
    total++; if (dn !== 1) begin bad++; $display("FAIL load_done_cnt got=%0d exp=1", dn); end
    total++; if (load_ovf !== 1'b0) begin bad++; $display("FAIL load_ovf_clean got=%b exp=0", load_ovf); end
    prog_sel = PW'(1); fetch_req = 1'b1;
    for (int a = 0; a < 3; a++) begin
      fetch_addr = AW'(a); tick;
      total++; if (inst_valid !== 1'b1 || inst_o !== ref_read(1, a)) begin bad++; $display("FAIL b2b_%0d got=%b/%h exp=1/%h", a, inst_valid, inst_o, ref_read(1, a)); end
    end
    fetch_req = 1'b0; tick;
    total++; if (inst_valid !== 1'b0 || inst_o !== ref_read(1, 2)) begin bad++; $display("FAIL hold got=%b/%h exp=0/%h", inst_valid, inst_o, ref_read(1, 2)); end
    fetch_one(0, 0, v, d, pe);
    total++; if (d !== FILLV) begin bad++; $display("FAIL bank0_untouched got=%h exp=%h", d, FILLV); end
  endtask

  task automatic test_overflow;
    int dn; logic v, pe; logic [7:0] d;
    beats.delete();
    for (int k = 0; k < 6; k++) beats.push_back(8'($urandom));
    run_load(2, 1'b1, dn);
    model_load(2, 6);
    total++; if (dn !== 1 || load_ovf !== 1'b1) begin bad++; $display("FAIL ovf got=%0d/%b exp=1/1", dn, load_ovf); end
    for (int a = 0; a < int'(DEPTH); a++) begin
      fetch_one(2, a, v, d, pe);
      total++; if (d !== ref_read(2, a)) begin bad++; $display("FAIL ovf_word_%0d got=%h exp=%h", a, d, ref_read(2, a)); end
    end
    fetch_one(3, 0, v, d, pe);
    total++; if (d !== FILLV) begin bad++; $display("FAIL no_spill got=%h exp=%h", d, FILLV); end
    rst_n = 1'b0; tick; rst_n = 1'b1;
    total++; if (load_ovf !== 1'b0) begin bad++; $display("FAIL ovf_reset got=%b exp=0", load_ovf); end
    fetch_one(2, 1, v, d, pe);
    total++; if (d !== ref_read(2, 1)) begin bad++; $display("FAIL mem_keep got=%h exp=%h", d, ref_read(2, 1)); end
  endtask

  task automatic test_out_of_range;
    logic v, pe; logic [7:0] d;
    fetch_one(2, DEPTH, v, d, pe);
    total++; if (v !== 1'b1 || d !== FILLV) begin bad++; $display("FAIL oor_addr got=%b/%h exp=1/%h", v, d, FILLV); end
    fetch_one(NP, 0, v, d, pe);
    total++; if (v !== 1'b1 || d !== FILLV) begin bad++; $display("FAIL oor_sel got=%b/%h exp=1/%h", v, d, FILLV); end
    fetch_one(7, 1, v, d, pe);
    total++; if (d !== FILLV) begin bad++; $display("FAIL oor_sel7 got=%h exp=%h", d, FILLV); end
  endtask

  task automatic test_same_cycle;
    logic v, pe; logic [7:0] d;
    load_bank = PW'(0); load_start = 1'b1;
    prog_sel = PW'(2); fetch_addr = AW'(0); fetch_req = 1'b1;
    tick;
    load_start = 1'b0; fetch_req = 1'b0;
    total++; if (inst_valid !== 1'b1 || inst_o !== ref_read(2, 0)) begin bad++; $display("FAIL same_fetch got=%b/%h exp=1/%h", inst_valid, inst_o, ref_read(2, 0)); end
    total++; if (fetch_ready !== 1'b0 || load_ready !== 1'b1) begin bad++; $display("FAIL same_state got=%b%b exp=01", fetch_ready, load_ready); end
    load_valid = 1'b1; load_data = 8'h5A; load_last = 1'b1;
    tick;
    load_valid = 1'b0; load_last = 1'b0;
    model[0][0] = 8'h5A;
    total++; if (load_done !== 1'b1 || fetch_ready !== 1'b0 || load_ready !== 1'b0) begin bad++; $display("FAIL done_state got=%b%b%b exp=100", load_done, fetch_ready, load_ready); end
    tick;
    fetch_one(0, 0, v, d, pe);
    total++; if (d !== ref_read(0, 0)) begin bad++; $display("FAIL same_after got=%h exp=%h", d, ref_read(0, 0)); end
  endtask

  task automatic test_reset_mid_load;
    int dn; logic v, pe; logic [7:0] d;
    beats = '{8'hA1, 8'hB2};
    run_load(3, 1'b0, dn);
    model_load(3, 2);
    rst_n = 1'b0; tick; rst_n = 1'b1;
    if (load_done) dn++;
    total++; if (fetch_ready !== 1'b1 || load_ready !== 1'b0) begin bad++; $display("FAIL midreset_state got=%b%b exp=10", fetch_ready, load_ready); end
    for (int k = 0; k < 3; k++) begin tick; if (load_done) dn++; end
    total++; if (dn !== 0) begin bad++; $display("FAIL midreset_done got=%0d exp=0", dn); end
    for (int a = 0; a < 3; a++) begin
      fetch_one(3, a, v, d, pe);
      total++; if (d !== ref_read(3, a)) begin bad++; $display("FAIL midreset_word_%0d got=%h exp=%h", a, d, ref_read(3, a)); end
    end
  endtask

  task automatic test_random;
    logic v, pe; logic [7:0] d; int dn;
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(3) == 0) begin
        int b;
        int n;
        b = int'($urandom_range(NP - 1));
        n = int'($urandom_range(6, 1));
        beats.delete();
        for (int k = 0; k < n; k++) beats.push_back(8'($urandom));
        run_load(b, 1'b1, dn);
        model_load(b, n);
        total++; if (dn !== 1 || load_ovf !== (n > int'(DEPTH))) begin bad++; $display("FAIL rnd_load_%0d got=%0d/%b exp=1/%b", it, dn, load_ovf, n > int'(DEPTH)); end
      end else begin
        int s;
        int a;
        s = int'($urandom_range(NP + 1));
        a = ($urandom_range(7) == 0) ? int'($urandom_range(255)) : int'($urandom_range(DEPTH));
        fetch_one(s, a, v, d, pe);
        total++; if (v !== 1'b1 || d !== ref_read(s, a) || pe !== 1'b0) begin bad++; $display("FAIL rnd_fetch_%0d sel=%0d addr=%0d got=%b/%h/%b exp=1/%h/0", it, s, a, v, d, pe, ref_read(s, a)); end
      end
    end
  endtask

`ifdef INST_MEM_PARITY_EN
  task automatic test_parity;
    logic v, pe; logic [7:0] d;
    dut.u_array.mem[3][0] = ~dut.u_array.mem[3][0];
    fetch_one(0, 3, v, d, pe);
    total++; if (v !== 1'b1 || pe !== 1'b1 || d !== (ref_read(0, 3) ^ 8'h01)) begin bad++; $display("FAIL perr_hit got=%b/%b/%h exp=1/1/%h", v, pe, d, ref_read(0, 3) ^ 8'h01); end
    fetch_one(0, 2, v, d, pe);
    total++; if (pe !== 1'b0) begin bad++; $display("FAIL perr_clean got=%b exp=0", pe); end
    fetch_one(0, 4, v, d, pe);
    total++; if (pe !== 1'b0 || d !== FILLV) begin bad++; $display("FAIL perr_oor got=%b/%h exp=0/%h", pe, d, FILLV); end
  endtask
`endif

  initial begin
    for (int b = 0; b < int'(NP); b++)
      for (int a = 0; a < int'(DEPTH); a++) model[b][a] = FILLV;
    test_reset;
    test_unloaded_fetch;
    test_load_back_to_back;
    test_overflow;
    test_out_of_range;
    test_same_cycle;
    test_reset_mid_load;
    test_random;
`ifdef INST_MEM_PARITY_EN
    test_parity;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_mem_banked.md
# inst_mem_banked

Parametrised, banked instruction memory for the 8-bit processor's fetch stage. It replaces the fixed combinational instruction table with a registered, one-cycle-latency synchronous read. It holds `NUM_PROG` independent program banks selectable at run time. A streaming load port lets a test harness or boot loader write a bank without resynthesis.

## Interface
- `DATA_W`, 8 — instruction width.
- `ADDR_W`, 8 — fetch address (PC) width, relative to the selected bank.
- `BANK_DEPTH`, 256 — words per bank; must be ≤ 2^`ADDR_W`.
- `NUM_PROG`, 4 — number of banks; `PSEL_W` = max(1, clog2(`NUM_PROG`)).
- `FILL`, 8'hFF — word returned for out-of-range reads and used to initialise unloaded words.

Ports:
- `clk` in 1 — single clock, rising edge.
- `rst_n` in 1 — synchronous, active-low reset.
- `prog_sel` in `PSEL_W` — bank used for fetches.
- `fetch_req` in 1 — fetch request.
- `fetch_addr` in `ADDR_W` — PC.
- `fetch_ready` out 1 — fetch accepted this cycle when high.
- `inst_valid` out 1 — `inst_o` is valid.
- `inst_o` out `DATA_W` — fetched instruction.
- `load_start` in 1 — begin loading bank `load_bank`.
- `load_bank` in `PSEL_W` — bank to load.
- `load_valid` in 1, `load_data` in `DATA_W`, `load_last` in 1 — load stream.
- `load_ready` out 1 — load beat accepted when `load_valid` is also high.
- `load_done` out 1 — one-cycle pulse at end of load.
- `load_ovf` out 1 — sticky flag: a load beat was dropped past the end of the bank.
- `parity_err` out 1 — present only with `INST_MEM_PARITY_EN`.

## Operation
- FSM states: `IDLE`, `LOAD`, `DONE`.
  - `IDLE`: `fetch_ready`=1, `load_ready`=0.
  - `IDLE` → `LOAD` on `load_start`. Latch `load_bank`, clear the write counter `wptr`, clear `load_ovf`.
  - `LOAD`: `fetch_ready`=0, `load_ready`=1. Each beat with `load_valid` writes `load_data` to `mem[load_bank*BANK_DEPTH + wptr]`, then `wptr`++.
    - If `wptr` == `BANK_DEPTH`, the write is dropped, `wptr` saturates and `load_ovf` is set.
    - A beat with `load_last` → `DONE`.
    - `load_start` in `LOAD` is ignored.
  - `DONE`: `load_done`=1 for one cycle, then → `IDLE`. `fetch_ready`=0 and `load_ready`=0.
- Fetch:
  - An accepted fetch reads `mem[prog_sel*BANK_DEPTH + fetch_addr]`.
  - If `fetch_addr` ≥ `BANK_DEPTH` or `prog_sel` ≥ `NUM_PROG`, the result is `FILL`.
- Bank index arithmetic is done at width `PSEL_W`+`ADDR_W`; there is no wrap into a neighbouring bank.
- Memory contents are not cleared by reset. They initialise to `FILL` at power-up and are preserved across `rst_n`.
- If `load_start` and `fetch_req` arrive in the same `IDLE` cycle, both take effect: the fetch reads the old contents and the FSM enters `LOAD`.

## Timing
- Reset values: `inst_valid`=0, `inst_o`=`FILL`, `load_done`=0, `load_ovf`=0, `parity_err`=0, state `IDLE`, `wptr`=0.
- `fetch_ready` and `load_ready` are combinational from state only. They do not depend on `fetch_req` or `load_valid`.
- Read latency is 1: a fetch accepted at edge N gives `inst_valid`=1 and data on `inst_o` after edge N.
  - `inst_valid` falls the cycle after no fetch is accepted.
  - `inst_o` holds its last value when `inst_valid` is low.
- Back-to-back fetches give one instruction per cycle.
- A write at edge N is visible to a fetch accepted at edge N+2 or later. Fetch is blocked through `LOAD`/`DONE`, so there is no read-during-write case.
- Reset mid-load: the FSM returns to `IDLE` and no `load_done` is issued. Words already written remain; `load_ovf` is cleared.

## Configuration
- `INST_MEM_PARITY_EN`:
  - Defined: each word stores an extra even-parity bit computed on write (and on `FILL` init). An accepted fetch recomputes parity, and `parity_err` is asserted aligned with `inst_valid` on mismatch. Out-of-range `FILL` reads never flag.
  - Undefined: no parity storage; the `parity_err` port does not exist.

## Structure
- Package `inst_mem_pkg` holds:
  - the FSM state enum (`IDLE`/`LOAD`/`DONE`);
  - default `FILL`;
  - the function `bank_index(bank, addr)` returning the flat address.
- One sub-module, `inst_mem_array`: a single-port synchronous RAM of depth `NUM_PROG*BANK_DEPTH`, with registered read, optional parity bit column, and `FILL` initialisation.
- The FSM, counter and range checks live in the top level.

## Test plan
- Reset, then fetch bank 0 at address 5 → after 1 cycle `inst_valid`=1, `inst_o`=8'hFF (unloaded).
- Load bank 1 with 3 words 8'hC1, 8'h90, 8'h88 (`load_last` on the third) → `load_done` pulses once. Then `prog_sel`=1, fetch addresses 0,1,2 back-to-back → 8'hC1, 8'h90, 8'h88 on consecutive cycles; bank 0 address 0 is still 8'hFF.
- `BANK_DEPTH`=4: stream 6 beats to bank 2 → the first 4 are stored, `load_ovf`=1, and bank 3 address 0 is still 8'hFF.
- `fetch_addr`=BANK_DEPTH → `inst_o`=`FILL`; `prog_sel`=`NUM_PROG` (when representable) → `FILL`.
- Assert `rst_n`=0 for one cycle after 2 beats of a load → state returns to `IDLE`, `fetch_ready`=1, no `load_done`, and the 2 written words read back.
- With `INST_MEM_PARITY_EN`: force-flip one stored bit of bank 0 address 3 → a fetch of address 3 gives `parity_err`=1 in the same cycle as `inst_valid`; a fetch of address 4 gives 0.
